// File: rtl/writeback_pkg.sv
// Shared types for the register write-back path: register index/data widths and the
// one-entry pending-write record used to stage returning load data.
package writeback_pkg;

  localparam int unsigned RegAddrWidth          = 5;
  localparam int unsigned RegDataWidth          = 32;
  localparam int unsigned DefaultLoadQueueDepth = 4;

  typedef logic [RegAddrWidth-1:0] reg_idx_t;
  typedef logic [RegDataWidth-1:0] reg_data_t;

  typedef struct packed {
    logic      valid;
    reg_idx_t  rd;
    reg_data_t data;
  } pending_write_t;

endpackage

// File: rtl/tag_fifo.sv
// Small synchronous FIFO with occupancy count; holds in-order return tags.
module tag_fifo #(
  parameter int unsigned Width = 5,
  parameter int unsigned Depth = 4,
  localparam int unsigned PtrW = $clog2(Depth),
  localparam int unsigned CntW = $clog2(Depth) + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [Width-1:0] data_i,
  input  logic             pop_i,
  output logic [Width-1:0] data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CntW-1:0]  count_o
);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             push_ok, pop_ok;

  always_comb begin
    full_o   = (count_q == CntW'(Depth));
    empty_o  = (count_q == '0);
    count_o  = count_q;
    data_o   = mem_q[rd_ptr_q];
    push_ok  = push_i && !full_o;
    pop_ok   = pop_i && !empty_o;
    // Pointers wrap naturally because Depth is a power of two.
    wr_ptr_d = push_ok ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
    rd_ptr_d = pop_ok ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
    count_d  = count_q;
    if (push_ok && !pop_ok) begin
      count_d = count_q + CntW'(1);
    end else if (!push_ok && pop_ok) begin
      count_d = count_q - CntW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

endmodule

// File: rtl/register_writeback.sv
// Single owner of the register-file write port: merges ALU results with in-order load
// responses and tracks outstanding load destinations for hazard stalls.
module register_writeback
  import writeback_pkg::*;
#(
  parameter int unsigned AddressBitWidth = RegAddrWidth,
  parameter int unsigned DataBitWidth    = RegDataWidth,
  parameter int unsigned LoadQueueDepth  = DefaultLoadQueueDepth
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       alu_valid,
  input  logic [AddressBitWidth-1:0] alu_rd,
  input  logic [DataBitWidth-1:0]    alu_data,
  input  logic                       load_issue_valid,
  input  logic [AddressBitWidth-1:0] load_issue_rd,
  output logic                       load_issue_ready,
  input  logic                       load_resp_valid,
  input  logic [DataBitWidth-1:0]    load_resp_data,
  output logic                       load_resp_ready,
  input  logic [AddressBitWidth-1:0] rs1,
  output logic                       rs1_busy,
  input  logic [AddressBitWidth-1:0] rs2,
  output logic                       rs2_busy,
  output logic [AddressBitWidth-1:0] rd,
  output logic                       rd_write_enable,
  output logic [DataBitWidth-1:0]    rd_data_in
);

  localparam int unsigned NumRegs = 2 ** AddressBitWidth;
  localparam int unsigned CntW    = $clog2(LoadQueueDepth) + 1;

  // The pending-write record is typed from the package, so widths must agree with it.
  if (AddressBitWidth != RegAddrWidth || DataBitWidth != RegDataWidth) begin : g_width_check
    $error("register_writeback widths must match writeback_pkg");
  end

  logic [NumRegs-1:0] sb_q, sb_d;
  pending_write_t     pend_q, pend_d;
  reg_idx_t           fifo_head;
  logic [CntW-1:0]    fifo_count;
  logic               fifo_full, fifo_empty;
  logic               alu_wr, commit, issue_fire, resp_fire;

  always_comb begin
    alu_wr           = alu_valid && (alu_rd != '0);
    commit           = pend_q.valid && !alu_wr;
    // A register still marked busy (including one committing now) stalls a new load to it.
    load_issue_ready = !rst && !fifo_full && !((load_issue_rd != '0) && sb_q[load_issue_rd]);
    load_resp_ready  = !rst && !fifo_empty && (!pend_q.valid || !alu_valid);
    issue_fire       = load_issue_valid && load_issue_ready;
    resp_fire        = load_resp_valid && load_resp_ready;
    rs1_busy         = !rst && (rs1 != '0) && sb_q[rs1];
    rs2_busy         = !rst && (rs2 != '0) && sb_q[rs2];
  end

  always_comb begin
    rd              = '0;
    rd_data_in      = '0;
    rd_write_enable = 1'b0;
    if (!rst) begin
      if (alu_wr) begin
        rd              = alu_rd;
        rd_data_in      = alu_data;
        rd_write_enable = 1'b1;
      end else if (pend_q.valid) begin
        rd              = pend_q.rd;
        rd_data_in      = pend_q.data;
        rd_write_enable = (pend_q.rd != '0);
      end
    end
  end

  always_comb begin
    sb_d   = sb_q;
    pend_d = pend_q;
    if (commit && (pend_q.rd != '0)) begin
      sb_d[pend_q.rd] = 1'b0;
    end
    if (issue_fire && (load_issue_rd != '0)) begin
      sb_d[load_issue_rd] = 1'b1;
    end
    if (resp_fire) begin
      pend_d.valid = 1'b1;
      pend_d.rd    = fifo_head;
      pend_d.data  = load_resp_data;
    end else if (commit) begin
      pend_d.valid = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sb_q   <= '0;
      pend_q <= '0;
    end else begin
      sb_q   <= sb_d;
      pend_q <= pend_d;
    end
  end

  tag_fifo #(
    .Width (AddressBitWidth),
    .Depth (LoadQueueDepth)
  ) u_tag_fifo (
    .clk_i   (clk),
    .rst_i   (rst),
    .push_i  (issue_fire),
    .data_i  (load_issue_rd),
    .pop_i   (resp_fire),
    .data_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  alu_rd_not_busy_a : assert property (@(posedge clk) disable iff (rst)
    (alu_valid && (alu_rd != '0)) |-> !sb_q[alu_rd])
    else $error("alu_rd targets a register with an outstanding load");

  count_bound_a : assert property (@(posedge clk) disable iff (rst)
    fifo_count <= CntW'(LoadQueueDepth))
    else $error("tag fifo count exceeds depth");

endmodule

// File: doc/register_writeback.md
Name: register_writeback

Overview:
- Write-side controller for the register file: the single owner of the `rd` / `rd_write_enable` / `rd_data_in` port.
- Merges two result producers into that one write port:
  - single-cycle ALU results;
  - in-order load responses returning from the cache/SDRAM path with variable latency.
- Keeps a per-register scoreboard of outstanding loads so the core can stall on RAW/WAW hazards.

Parameters:
- AddressBitWidth, 5, register index width (2**AddressBitWidth registers).
- DataBitWidth, 32, register data width.
- LoadQueueDepth, 4, maximum outstanding loads (power of two, >=2).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- alu_valid  in  1  ALU result present this cycle; never stalled.
- alu_rd  in  AddressBitWidth  ALU destination.
- alu_data  in  DataBitWidth  ALU result.
- load_issue_valid  in  1  core issues a load.
- load_issue_rd  in  AddressBitWidth  load destination.
- load_issue_ready  out  1  issue accepted when valid&&ready.
- load_resp_valid  in  1  memory returns load data (in issue order).
- load_resp_data  in  DataBitWidth  load data.
- load_resp_ready  out  1  response accepted when valid&&ready.
- rs1  in  AddressBitWidth  hazard query index 1.
- rs1_busy  out  1  rs1 has an outstanding load.
- rs2  in  AddressBitWidth  hazard query index 2.
- rs2_busy  out  1  rs2 has an outstanding load.
- rd  out  AddressBitWidth  register file write index.
- rd_write_enable  out  1  register file write strobe.
- rd_data_in  out  DataBitWidth  register file write data.

Behaviour:
- Reset clock and polarity:
  - One clock domain (`clk`).
  - `rst` is synchronous and active-high.
  - While `rst` is high: tag FIFO emptied, scoreboard cleared, pending-write register emptied; `rd_write_enable`=0, `load_issue_ready`=0, `load_resp_ready`=0, `rs1_busy`=`rs2_busy`=0, `rd`=0, `rd_data_in`=0.
  - Reset mid-operation drops all outstanding loads; the memory side is reset together.
- State:
  - Tag FIFO of issued load destinations, LoadQueueDepth entries, with count.
  - Scoreboard: one bit per register.
  - One-entry pending-write register (valid, rd, data).
- Issue:
  - `load_issue_ready` = !rst && count<LoadQueueDepth && !(load_issue_rd!=0 && scoreboard[load_issue_rd]). The second term is a WAW stall.
  - On accept: push the tag; set `scoreboard[load_issue_rd]` if nonzero.
  - rd=0 loads are tracked but never written.
- Response:
  - `load_resp_ready` = !rst && count>0 && (!pend_valid || !alu_valid).
  - On accept: pop the tag; load {tag, data} into the pending register.
  - A same-cycle commit of the old pending entry plus a new accept is allowed.
  - A response with count=0 is ignored; ready is low in that case.
- Write-port arbitration (combinational outputs, zero latency):
  - `alu_valid` && `alu_rd`!=0 -> write ALU result.
  - Else if `pend_valid` -> write pending entry. This is a commit: clear pend_valid and clear `scoreboard[pend_rd]` at the clock edge.
  - Pending entry with rd=0 commits with `rd_write_enable`=0.
  - ALU with rd=0 does not consume the port; pending may commit that cycle.
- Concurrency and hazards:
  - Simultaneous issue and response: push and pop both occur; count unchanged.
  - Issue to a register whose commit is happening this cycle is stalled one cycle (bit still set).
  - `rsN_busy` = rsN!=0 && scoreboard[rsN], combinational. It drops the cycle after commit; data is then in the register file.
- Protocol precondition: `alu_rd` is never a busy register (core checks busy). Covered by a simulation assertion.
- FIFO pointers wrap modulo LoadQueueDepth; count is AddressBitWidth-independent, width $clog2(LoadQueueDepth)+1.

Decomposition:
- Package `writeback_pkg`: `reg_idx_t` (AddressBitWidth), `reg_data_t` (DataBitWidth), `pending_write_t` struct {valid, rd, data}.
- One sub-module: `tag_fifo` (synchronous FIFO: push/pop/full/empty/count, sync active-high reset), reused for other in-order return queues.

Test Plan:
- Reset: assert `rst` 3 cycles with alu_valid=1, alu_rd=5 -> rd_write_enable=0, both readies 0; after release, load_issue_ready=1.
- ALU path: alu_valid=1, alu_rd=3, alu_data=0xDEADBEEF -> same cycle rd=3, rd_write_enable=1, rd_data_in=0xDEADBEEF; alu_rd=0 -> no write.
- Load round trip: issue rd=7 -> rs1=7 busy next cycle; resp 0x12345678 -> write rd=7 next cycle, busy cleared the cycle after.
- Collision: pending load rd=9 with alu_valid held 3 cycles (rd=4) -> ALU writes 3 cycles, load_resp_ready=0, rd=9 commits on the 4th.
- Full/WAW: issue rd=1,2,3,4 without responses -> ready low on the 5th; re-issue rd=2 after one pop -> stalled until rd=2 commits.
- Order/rd=0: issue rd=0 then rd=6; respond twice back-to-back -> no write for the first, rd=6 gets the second data, count returns to 0.
